// File: rtl/pjdl_receive.sv
// PJDL receiver: synchronises the PJON line, checks the sync train, decodes
// LSB-first bytes and queues them in a small FIFO drained over AXI-Stream.

package pjdl_receive_pkg;
  typedef struct packed {
    logic [7:0] data;
    logic [0:0] strb;
    logic [0:0] keep;
    logic       last;
    logic [0:0] user;
  } axis_t_chan_t;
  typedef struct packed {
    logic         tvalid;
    axis_t_chan_t t;
  } axis_req_t;
  typedef struct packed {
    logic tready;
  } axis_rsp_t;
endpackage

module pjdl_receive #(
  parameter int unsigned BufferSize = 2,
  parameter type axis_req_t = pjdl_receive_pkg::axis_req_t,
  parameter type axis_rsp_t = pjdl_receive_pkg::axis_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  output axis_req_t   axis_write_req_o,
  input  axis_rsp_t   axis_write_rsp_i,
  input  logic        sending_in_progress_i,
  input  logic        start_ack_receiving_i,
  output logic        receiving_in_progress_o,
  output logic        frame_error_o,
  output logic        overflow_o,
  input  logic        pjon_i,
  input  logic [19:0] pjdl_spec_preamble_i,
  input  logic [13:0] pjdl_spec_pad_i,
  input  logic [11:0] pjdl_spec_data_i
);
  typedef enum logic [2:0] {
    S_DISABLED, S_IDLE, S_SYNC_HIGH, S_SYNC_LOW, S_BYTE_SYNC, S_BYTE_BITS, S_ACK_WAIT
  } state_e;

  localparam int unsigned PW = (BufferSize > 1) ? $clog2(BufferSize) : 1;
  localparam int unsigned CW = $clog2(BufferSize + 1);

  // Preamble length is not checked: the first high merges with the first pad.
  logic unused_preamble;
  assign unused_preamble = ^pjdl_spec_preamble_i;

  // Segment lengths and tolerances, all in 20-bit cycle counts.
  logic [19:0] p_len, d_len, tp, td, p_half, d_half, d_nine, ack_tmo;
  assign p_len   = 20'(pjdl_spec_pad_i) + 20'd1;
  assign d_len   = 20'(pjdl_spec_data_i) + 20'd1;
  assign tp      = p_len >> 2;
  assign td      = d_len >> 2;
  assign p_half  = p_len >> 1;
  assign d_half  = d_len >> 1;
  assign d_nine  = (d_len << 3) + d_len;
  assign ack_tmo = p_len + (d_len << 2);

  logic [1:0] sync_q, sync_d;
  logic       line_prev_q, line_prev_d;
  logic       line, rise, fall;
  assign line        = sync_q[1];
  assign rise        = line & ~line_prev_q;
  assign fall        = ~line & line_prev_q;
  assign sync_d      = {sync_q[0], pjon_i};
  assign line_prev_d = line;

  // Two-flop synchroniser plus edge-detect history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q      <= '0;
      line_prev_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      line_prev_q <= line_prev_d;
    end
  end

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d, bnd_q, bnd_d, nxt_q, nxt_d;
  logic [1:0]  sync_cnt_q, sync_cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d, hold_q, hold_d, byte_new;
  logic        first_q, first_d, sampled_q, sampled_d, hold_vld_q, hold_vld_d;
  logic        ack_q, ack_d, ferr_q, ferr_d, rip_q, rip_d, err;
  logic        push, push_last, push_user;
  logic [7:0]  push_data;

  assign byte_new = {line, shreg_q[7:1]};

  // Receive FSM: sync train, byte framing, ack byte, and push requests.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + 20'd1;
    bnd_d      = bnd_q;
    nxt_d      = nxt_q;
    sync_cnt_d = sync_cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    hold_d     = hold_q;
    first_d    = first_q;
    sampled_d  = sampled_q;
    hold_vld_d = hold_vld_q;
    ack_d      = ack_q;
    ferr_d     = 1'b0;
    err        = 1'b0;
    push       = 1'b0;
    push_data  = hold_q;
    push_last  = 1'b0;
    push_user  = 1'b0;
    case (state_q)
      S_DISABLED: begin
        if (enable_i) begin
          if (start_ack_receiving_i) begin
            state_d = S_ACK_WAIT;
            cnt_d   = 20'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (start_ack_receiving_i) begin
          state_d = S_ACK_WAIT;
          cnt_d   = 20'd1;
        end else if (!sending_in_progress_i && rise) begin
          state_d    = S_SYNC_HIGH;
          cnt_d      = 20'd1;
          sync_cnt_d = 2'd0;
          first_d    = 1'b1;
        end
      end
      S_SYNC_HIGH: begin
        // First high has no upper bound because the preamble merges into it.
        if (fall) begin
          if (cnt_q >= p_len - tp && (first_q || cnt_q <= p_len + tp)) begin
            state_d = S_SYNC_LOW;
            cnt_d   = 20'd1;
          end else begin
            err = 1'b1;
          end
        end else if (!first_q && cnt_q > p_len + tp) begin
          err = 1'b1;
        end
      end
      S_SYNC_LOW: begin
        if (rise) begin
          if (cnt_q >= d_len - td && cnt_q <= d_len + td) begin
            cnt_d = 20'd1;
            if (sync_cnt_q == 2'd2) begin
              state_d   = S_BYTE_SYNC;
              bnd_d     = 20'd0;
              sampled_d = 1'b0;
              first_d   = 1'b1;
            end else begin
              sync_cnt_d = sync_cnt_q + 2'd1;
              first_d    = 1'b0;
              state_d    = S_SYNC_HIGH;
            end
          end else begin
            err = 1'b1;
          end
        end else if (cnt_q > d_len + td) begin
          err = 1'b1;
        end
      end
      S_BYTE_SYNC: begin
        // Edges before the mid-pad sample are ignored: they are bit-7 edges
        // or the end-of-frame release of the line.
        if (!sampled_q) begin
          if (cnt_q == bnd_q + p_half) begin
            if (!line) begin
              if (first_q) begin
                err = 1'b1;
              end else begin
                push       = hold_vld_q;
                push_last  = 1'b1;
                hold_vld_d = 1'b0;
                state_d    = S_IDLE;
              end
            end else begin
              sampled_d  = 1'b1;
              push       = hold_vld_q;
              hold_vld_d = 1'b0;
            end
          end
        end else if (fall) begin
          if (cnt_q >= bnd_q + p_len - tp) begin
            state_d = S_BYTE_BITS;
            cnt_d   = 20'd1;
            nxt_d   = d_len + d_half;
            bit_d   = 3'd0;
          end else begin
            err = 1'b1;
          end
        end else if (cnt_q > bnd_q + p_len + tp) begin
          err = 1'b1;
        end
      end
      S_BYTE_BITS: begin
        // The low segment before bit 0 must not end early.
        if (line && cnt_q <= d_len - td) begin
          err = 1'b1;
        end else if (cnt_q == nxt_q) begin
          shreg_d = byte_new;
          nxt_d   = nxt_q + d_len;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (ack_q) begin
              push      = 1'b1;
              push_data = byte_new;
              push_last = 1'b1;
              push_user = 1'b1;
              ack_d     = 1'b0;
              state_d   = S_IDLE;
            end else begin
              hold_d     = byte_new;
              hold_vld_d = 1'b1;
              bnd_d      = d_nine;
              sampled_d  = 1'b0;
              first_d    = 1'b0;
              state_d    = S_BYTE_SYNC;
            end
          end
        end
      end
      S_ACK_WAIT: begin
        if (fall) begin
          state_d = S_BYTE_BITS;
          cnt_d   = 20'd1;
          nxt_d   = d_len + d_half;
          bit_d   = 3'd0;
          ack_d   = 1'b1;
        end else if (cnt_q >= ack_tmo) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Timing violation: flush any held byte as end of frame, abort the rest.
    if (err) begin
      ferr_d     = 1'b1;
      state_d    = S_IDLE;
      ack_d      = 1'b0;
      push       = hold_vld_q;
      push_data  = hold_q;
      push_last  = 1'b1;
      push_user  = 1'b0;
      hold_vld_d = 1'b0;
    end
    if (!enable_i) begin
      state_d    = S_DISABLED;
      hold_vld_d = 1'b0;
      ack_d      = 1'b0;
      push       = 1'b0;
      ferr_d     = 1'b0;
    end
    rip_d = (state_d != S_IDLE) && (state_d != S_DISABLED);
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bnd_q      <= '0;
      nxt_q      <= '0;
      sync_cnt_q <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      hold_q     <= '0;
      first_q    <= 1'b0;
      sampled_q  <= 1'b0;
      hold_vld_q <= 1'b0;
      ack_q      <= 1'b0;
      ferr_q     <= 1'b0;
      rip_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bnd_q      <= bnd_d;
      nxt_q      <= nxt_d;
      sync_cnt_q <= sync_cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      hold_q     <= hold_d;
      first_q    <= first_d;
      sampled_q  <= sampled_d;
      hold_vld_q <= hold_vld_d;
      ack_q      <= ack_d;
      ferr_q     <= ferr_d;
      rip_q      <= rip_d;
    end
  end

  assign receiving_in_progress_o = rip_q;
  assign frame_error_o           = ferr_q;

  logic [9:0]    mem_q [BufferSize];
  logic [9:0]    mem_d [BufferSize];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] fill_q, fill_d;
  logic          full, empty, do_push, do_pop, ovf_d, ovf_q;

  // Output FIFO: a push while full is dropped and flagged.
  always_comb begin
    full    = (fill_q == CW'(BufferSize));
    empty   = (fill_q == '0);
    do_push = push && !full;
    do_pop  = !empty && axis_write_rsp_i.tready;
    ovf_d   = push && full;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    fill_d  = fill_q;
    if (do_push) begin
      mem_d[wr_q] = {push_user, push_last, push_data};
      wr_d        = (wr_q == PW'(BufferSize - 1)) ? '0 : wr_q + PW'(1);
    end
    if (do_pop) rd_d = (rd_q == PW'(BufferSize - 1)) ? '0 : rd_q + PW'(1);
    if (do_push && !do_pop) fill_d = fill_q + CW'(1);
    else if (!do_push && do_pop) fill_d = fill_q - CW'(1);
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(BufferSize); i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fill_q <= fill_d;
      ovf_q  <= ovf_d;
    end
  end

  assign overflow_o = ovf_q;

  // AXI-Stream beat from the FIFO head.
  always_comb begin
    axis_write_req_o              = '0;
    axis_write_req_o.tvalid       = !empty;
    axis_write_req_o.t.data[7:0]  = mem_q[rd_q][7:0];
    axis_write_req_o.t.last       = mem_q[rd_q][8];
    axis_write_req_o.t.user[0]    = mem_q[rd_q][9];
    axis_write_req_o.t.keep[0]    = 1'b1;
    axis_write_req_o.t.strb[0]    = 1'b1;
  end
endmodule

// File: doc/pjdl_receive.md
Name: pjdl_receive

Overview:
- Receiving half of the PJDL strategy. Samples the shared PJON line, detects the frame-initialisation sync train, and decodes PJDL bytes LSB first.
- Pushes decoded bytes into an output FIFO drained over an AXI-Stream master port to Layer 3 or the wrapper.
- Also receives the single response byte that follows an ack request, triggered by pjdl_send's start_ack_receiving_o.

Parameters:
- BufferSize, 2, output FIFO depth in bytes, minimum 1.
- axis_req_t, logic, AXI-Stream request struct (tvalid, t.data, t.last, t.keep, t.strb, t.user).
- axis_rsp_t, logic, AXI-Stream response struct (tready).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- enable_i  in  1  allow receiving. When low, FSM is held in Disabled; FIFO and AXIS keep draining.
- axis_write_req_o  out  axis_req_t  decoded byte stream.
- axis_write_rsp_i  in  axis_rsp_t  downstream tready.
- sending_in_progress_i  in  1  local sender active; line is ignored.
- start_ack_receiving_i  in  1  one-cycle pulse; enter AckWait.
- receiving_in_progress_o  out  1  FSM not in Idle or Disabled.
- frame_error_o  out  1  one-cycle pulse on timing violation.
- overflow_o  out  1  one-cycle pulse when a byte is dropped because the FIFO is full.
- pjon_i  in  1  raw line input.
- pjdl_spec_preamble_i  in  20  preamble length minus 1, in cycles (not checked; may be 0).
- pjdl_spec_pad_i  in  14  pad length minus 1, in cycles.
- pjdl_spec_data_i  in  12  data-bit length minus 1, in cycles.

Behaviour:
- Input sync: pjon_i passes through 2 flops. All edges and samples below refer to the synchronised line.
- Segment lengths: P = pad+1, D = data+1, TP = P>>2, TD = D>>2. Arithmetic is done in 20 bits, zero-extended.
- Counter: a 20-bit cycle counter restarts at 0 on every resync edge.
- Reset: state Idle; FIFO empty; tvalid=0; holding register invalid. receiving_in_progress_o, frame_error_o and overflow_o are all 0.
- Disabled: entered from any state when enable_i=0; the held byte is discarded. Returns to Idle when enable_i=1.
- Idle: ignores the line while sending_in_progress_i=1. On a rising edge, go to SyncHigh with sync_cnt=0.
- SyncHigh: a falling edge is required with measured high width >= P-TP; no upper bound, so the preamble merges with the first pad. On that edge go to SyncLow.
- SyncLow: a rising edge is required at D±TD.
  - sync_cnt increments on the rising edge.
  - If sync_cnt reaches 3, set the boundary there and go to ByteSync.
  - Otherwise go to SyncHigh, whose width check is now P±TP.
- ByteSync:
  - Line is sampled at boundary+P/2.
  - Sample = 0 on the first byte after the sync train: frame error; return to Idle.
  - Sample = 0 on a later byte: end of frame. If a byte is held, push it with tlast=1.
  - Sample = 1: the held byte, if any, is pushed with tlast=0. Then a falling edge is required at boundary+P±TP; it resyncs the counter.
  - Missing or early edge: frame_error_o pulses; the held byte is pushed with tlast=1; go to Idle.
- ByteSyncLow: the line must stay low until D+D/2. Bits 0..7 are then sampled at (k+1)·D + D/2 after resync, k=0..7, shifted LSB first.
- Byte complete: after bit 7 sample, the byte goes to the holding register. Boundary = resync + 9·D; go to ByteSync.
- AckWait: entered on start_ack_receiving_i from Idle or Disabled-exit; overrides sending_in_progress_i.
  - Decodes exactly one byte via the ByteSync rules, without the sync train or the end-of-frame check.
  - Pushes it with tlast=1, user[0]=1, then goes to Idle.
  - No falling edge within P+4·D cycles: return to Idle silently, no push.
- Push:
  - A push on a full FIFO drops the byte and pulses overflow_o.
  - The held byte is still pushed on frame error; a byte in progress is discarded.
- AXIS output:
  - tvalid=!empty; pop on tvalid&&tready.
  - keep=1, strb=1; data[7:0] = byte, upper bits 0.
  - user[0]=ack flag, other user bits 0.
- Simultaneous events: enable_i=0 beats everything. Reset mid-frame leaves the FIFO empty and the FSM in Idle.

Test Plan:
- Clean frame: pad=9, data=29, preamble=99; frame 0xA5,0x3C; tready=1 → beats {0xA5,last=0},{0x3C,last=1}, no errors.
- Merged high: byte 0x80 followed by byte 0xFF with pad=9, data=29; bit7=1 merges with next pad → both bytes decoded correctly, 0xFF last.
- Timing error: second sync low stretched to 45 cycles with D=30 → frame_error_o one pulse, no beats, state Idle.
- Overflow: BufferSize=2, tready=0, 3-byte frame → first 2 bytes kept, overflow_o pulses once; releasing tready → 2 beats, second without tlast.
- Ack: start_ack_receiving_i pulse, then pad, low, 0x06 → beat {0x06,last=1,user[0]=1}. With no line activity for P+4·D cycles → Idle, no beat.
- Disable/reset: enable_i=0 mid-byte → Disabled, receiving_in_progress_o=0, held byte dropped. rst_i asserted mid-frame → tvalid=0 asynchronously.
